i2s_rx_deserializer: RTL and testbench
======================================

// Module: i2s_rx_deserializer
// PURPOSE
//  Receives a standard (Philips) I2S stream and deserializes it into parallel left/right sample words.
//  Oversamples BCLK, LRCLK and DATA in the clk_ref_external domain and presents one L/R pair per frame.
//  The output uses a valid/ready handshake.
//  Receive-side counterpart of the USB-to-I2S generator. Sits between the I2S pads and the core input select.
// PARAMETERS
//  DATA_W      24     output word width; serial bits beyond DATA_W in a slot are discarded
//  SYNC_STAGES 2      synchronizer flops per input (>=2)
//  MIN_BITS    8      minimum bits per slot; fewer bits raises frame_err
//  TIMEOUT     1024   clk cycles without a synced BCLK rise before lock is dropped
// PORTS
//  clk_ref_external in  1       system clock; BCLK must be <= clk_ref_external/4
//  rst_n            in  1       asynchronous, active-low reset
//  enable           in  1       0 = hold in IDLE and clear all state except the output regs
//  i2s_bclk         in  1       asynchronous serial bit clock
//  i2s_lrclk        in  1       asynchronous word select (0 = left)
//  i2s_data         in  1       asynchronous serial data, MSB first
//  out_left         out DATA_W  left sample, left-aligned
//  out_right        out DATA_W  right sample, left-aligned
//  out_valid        out 1       pair available; held until accepted
//  out_ready        in  1       consumer accepts the pair when out_valid&&out_ready
//  overrun          out 1       1-cycle pulse: new pair arrived while out_valid&&!out_ready
//  frame_err        out 1       1-cycle pulse: slot shorter than MIN_BITS
//  locked           out 1       set after the first complete good L+R pair
//  lr_period        out 16      clk cycles per LRCLK frame (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; shift register, bit counter and holding register cleared.
//  - Each input passes through SYNC_STAGES flops. bclk_rise = synced BCLK 0->1 (registered edge detect).
//    On bclk_rise, sample synced lrclk and data. lr_prev holds the lrclk value from the previous rise.
//  - FSM:
//    - IDLE->HUNT when enable=1.
//    - HUNT->LEFT on a bclk_rise with lrclk=0 and lr_prev=1. That bit is discarded; bit_cnt=0.
//    - LEFT<->RIGHT on each lrclk change.
//    - Any state->IDLE when enable=0.
//  - In LEFT/RIGHT on bclk_rise:
//    - If bit_cnt<DATA_W, shift data into sreg.
//    - bit_cnt increments and saturates at 63.
//    - If lrclk!=lr_prev (slot boundary), the bit on that edge is still the LSB of the ending slot (I2S 1-bit delay).
//      Shift it in first, then close the slot.
//  - Slot close, with n = bits captured (<=DATA_W):
//    - word = sreg << (DATA_W-n), i.e. zero-pad the LSBs.
//    - Then bit_cnt=0 and sreg=0.
//    - LEFT close: word goes to left_hold.
//    - RIGHT close: out_left<=left_hold and out_right<=word; out_valid<=1; locked<=1.
//  - Latency: out_valid rises SYNC_STAGES+2 clk cycles after the i2s_bclk pin rise carrying the right-slot LSB.
//  - Handshake:
//    - out_valid clears on the cycle after out_valid&&out_ready.
//    - A new pair completing in the same cycle as acceptance loads the new pair, keeps out_valid=1 and does not pulse overrun.
//    - A pair arriving while out_valid&&!out_ready overwrites out_left/out_right and pulses overrun.
//  - Short slot (total bits <MIN_BITS at close):
//    - frame_err pulses, locked<=0, state HUNT.
//    - The pending left_hold is dropped and no output is produced.
//    - The first slot after HUNT is checked normally.
//  - Timeout: a TIMEOUT-cycle idle counter is reset on every bclk_rise. On expiry: locked<=0, HUNT, no frame_err.
//  - Disable or reset mid-word: the partial word is discarded. An out_valid pair already presented stays until accepted (disable only).
//  - Long slot (>DATA_W bits): extra LSBs are ignored. bit_cnt saturation prevents wrap.
// CONFIGURATION
//  - Macro KOSEI_I2S_RX_RATE_DET_EN defined:
//    - A 16-bit counter counts clk cycles between successive LEFT entries (lrclk falling at bclk_rise). It saturates at 16'hFFFF.
//    - lr_period is updated at each LEFT entry while locked, and held otherwise.
//  - Macro not defined: counter absent; lr_period tied to 16'h0000.
// TESTING
//  - DATA_W=24, BCLK=clk/8, 32-bit slots, L=0xA5A5A5, R=0x5A5A5A, out_ready=1
//    -> out_left=A5A5A5, out_right=5A5A5A, one out_valid pulse per frame, locked=1 after the first frame.
//  - 16-bit slots, L=0x1234, R=0xBEEF -> out_left=0x123400, out_right=0xBEEF00.
//  - out_ready=0 for 2 frames -> second frame pulses overrun once; outputs hold frame-2 data.
//    Then raising out_ready clears out_valid next cycle.
//  - 4-bit right slot injected -> frame_err pulse, locked=0, no out_valid.
//    Next 2 good frames -> out_valid resumes with correct data.
//  - BCLK stopped for 1100 clk -> locked=0 with no frame_err. Restart -> relock after one frame.
//    rst_n pulsed mid-left-slot -> all outputs 0; first output is the next complete frame.
//  - RATE_DET_EN, BCLK=clk/8, 64 BCLK/frame -> lr_period=512. Without the macro -> lr_period=0.

Source files
------------

// File: rtl/i2s_rx_deserializer.sv
// Philips I2S receiver: oversamples BCLK/LRCLK/DATA and emits one left-aligned L/R pair per frame.
// Latency: out_valid rises SYNC_STAGES+2 cycles after the BCLK pin rise that carries the right-slot LSB.
// Backpressure: pair held until out_valid&&out_ready; a newer pair overwrites it and pulses overrun.
// LRCLK rate detector is built only when KOSEI_I2S_RX_RATE_DET_EN is defined; otherwise lr_period reads 0.
module i2s_rx_deserializer #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_BITS    = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk_ref_external,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              i2s_bclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_data,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              frame_err,
    output logic              locked,
    output logic [15:0]       lr_period
);
    localparam int              TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);
    localparam logic [6:0]      DW7    = 7'(DATA_W);
    localparam logic [6:0]      MIN7   = 7'(MIN_BITS);

    typedef enum logic [1:0] {IDLE, HUNT, LEFT, RIGHT} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d, lr_sync_q, lr_sync_d, data_sync_q, data_sync_d;
    logic                   bclk_last_q, bclk_last_d, bclk_rise_q, bclk_rise_d;
    logic                   lr_smp_q, lr_smp_d, data_smp_q, data_smp_d, lr_prev_q, lr_prev_d;
    logic [DATA_W-1:0]      sreg_q, sreg_d, left_hold_q, left_hold_d;
    logic [DATA_W-1:0]      out_left_q, out_left_d, out_right_q, out_right_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic                   out_valid_q, out_valid_d, overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d, locked_q, locked_d;
    logic                   left_entry;
    logic [DATA_W-1:0]      sreg_shift, slot_word;
    logic [5:0]             cnt_inc;
    logic [6:0]             n_cap;

    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
        lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], i2s_data};
        // Registered edge detect; lrclk/data are re-registered so they stay aligned with the rise strobe.
        bclk_last_d = bclk_sync_q[SYNC_STAGES-1];
        bclk_rise_d = bclk_sync_q[SYNC_STAGES-1] & ~bclk_last_q;
        lr_smp_d    = lr_sync_q[SYNC_STAGES-1];
        data_smp_d  = data_sync_q[SYNC_STAGES-1];

        state_d     = state_q;
        lr_prev_d   = lr_prev_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        left_hold_d = left_hold_q;
        idle_cnt_d  = idle_cnt_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q & ~out_ready;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        locked_d    = locked_q;
        left_entry  = 1'b0;

        sreg_shift = ({1'b0, bit_cnt_q} < DW7) ? {sreg_q[DATA_W-2:0], data_smp_q} : sreg_q;
        cnt_inc    = (bit_cnt_q == 6'd63) ? 6'd63 : bit_cnt_q + 6'd1;
        n_cap      = ({1'b0, cnt_inc} > DW7) ? DW7 : {1'b0, cnt_inc};
        slot_word  = sreg_shift << (DW7 - n_cap);

        if (!enable) begin
            state_d     = IDLE;
            lr_prev_d   = 1'b0;
            sreg_d      = '0;
            bit_cnt_d   = '0;
            left_hold_d = '0;
            idle_cnt_d  = '0;
            locked_d    = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = HUNT;
        end else if (bclk_rise_q) begin
            idle_cnt_d = '0;
            lr_prev_d  = lr_smp_q;
            if (state_q == HUNT) begin
                // The falling-LRCLK bit belongs to an unseen right slot and is dropped.
                if (!lr_smp_q && lr_prev_q) begin
                    state_d    = LEFT;
                    bit_cnt_d  = '0;
                    sreg_d     = '0;
                    left_entry = 1'b1;
                end
            end else begin
                sreg_d    = sreg_shift;
                bit_cnt_d = cnt_inc;
                if (lr_smp_q != lr_prev_q) begin
                    sreg_d    = '0;
                    bit_cnt_d = '0;
                    if ({1'b0, cnt_inc} < MIN7) begin
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        left_hold_d = '0;
                        state_d     = HUNT;
                    end else if (state_q == LEFT) begin
                        left_hold_d = slot_word;
                        state_d     = RIGHT;
                    end else begin
                        out_left_d  = left_hold_q;
                        out_right_d = slot_word;
                        out_valid_d = 1'b1;
                        overrun_d   = out_valid_q & ~out_ready;
                        locked_d    = 1'b1;
                        state_d     = LEFT;
                        left_entry  = 1'b1;
                    end
                end
            end
        end else if (idle_cnt_q == TO_MAX) begin
            idle_cnt_d  = '0;
            locked_d    = 1'b0;
            sreg_d      = '0;
            bit_cnt_d   = '0;
            left_hold_d = '0;
            state_d     = HUNT;
        end else begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_ref_external or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            data_sync_q <= '0;
            bclk_last_q <= 1'b0;
            bclk_rise_q <= 1'b0;
            lr_smp_q    <= 1'b0;
            data_smp_q  <= 1'b0;
            lr_prev_q   <= 1'b0;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            left_hold_q <= '0;
            idle_cnt_q  <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_sync_q <= bclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            data_sync_q <= data_sync_d;
            bclk_last_q <= bclk_last_d;
            bclk_rise_q <= bclk_rise_d;
            lr_smp_q    <= lr_smp_d;
            data_smp_q  <= data_smp_d;
            lr_prev_q   <= lr_prev_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            left_hold_q <= left_hold_d;
            idle_cnt_q  <= idle_cnt_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
        end
    end

`ifdef KOSEI_I2S_RX_RATE_DET_EN
    logic [15:0] rate_cnt_q, rate_cnt_d, lr_period_q, lr_period_d;

    // Restarting at 1 makes the value seen at the next entry equal the full frame length.
    always_comb begin
        rate_cnt_d  = (rate_cnt_q == 16'hFFFF) ? rate_cnt_q : rate_cnt_q + 16'd1;
        lr_period_d = lr_period_q;
        if (!enable) begin
            rate_cnt_d = '0;
        end else if (left_entry) begin
            rate_cnt_d = 16'd1;
            if (locked_q) lr_period_d = rate_cnt_q;
        end
    end

    always_ff @(posedge clk_ref_external or negedge rst_n) begin
        if (!rst_n) begin
            rate_cnt_q  <= '0;
            lr_period_q <= '0;
        end else begin
            rate_cnt_q  <= rate_cnt_d;
            lr_period_q <= lr_period_d;
        end
    end

    assign lr_period = lr_period_q;
`else
    assign lr_period = 16'h0000;
`endif

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: drives I2S frames (BCLK = clk/8) with random words and checks pairs,
// handshake pulses and lock status against an arithmetic model of slot capture.
module tb_i2s_rx_deserializer;
    localparam int DW   = 24;
    localparam int HALF = 4;

    logic          clk_ref_external;
    logic          rst_n, enable, i2s_bclk, i2s_lrclk, i2s_data, out_ready;
    logic [DW-1:0] out_left, out_right;
    logic          out_valid, overrun, frame_err, locked;
    logic [15:0]   lr_period;

    i2s_rx_deserializer dut (
        .clk_ref_external(clk_ref_external), .rst_n(rst_n), .enable(enable),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .frame_err(frame_err), .locked(locked), .lr_period(lr_period)
    );

    initial begin
        clk_ref_external = 1'b0;
        forever #5 clk_ref_external = ~clk_ref_external;
    end

    int            n_assert = 0, n_fail = 0;
    logic [DW-1:0] acc_l[$], acc_r[$], exp_l[$], exp_r[$];
    int            vld_rises = 0, ovr_cnt = 0, ferr_cnt = 0;
    logic          vld_prev = 1'b0;

    always @(negedge clk_ref_external) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                acc_l.push_back(out_left);
                acc_r.push_back(out_right);
            end
            if (out_valid && !vld_prev) vld_rises <= vld_rises + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
        end
        vld_prev <= out_valid;
    end

    int   rd_idx = 0, b_vld, b_ovr, b_ferr;
    logic lead_sent = 1'b0, pend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Top DW bits of an n-bit slot value, zero-padded on the right when the slot is short.
    function automatic logic [DW-1:0] exp_word(input logic [63:0] v, input int n);
        logic [63:0] t;
        if (n >= DW) t = v >> (n - DW);
        else         t = v << (DW - n);
        return t[DW-1:0];
    endfunction

    function automatic logic [63:0] rand_val(input int n);
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (n < 64) v = v & ((64'd1 << n) - 64'd1);
        return v;
    endfunction

    task automatic send_bit(input logic lr, input logic d);
        i2s_bclk = 1'b0; i2s_lrclk = lr; i2s_data = d;
        repeat (HALF) @(negedge clk_ref_external);
        i2s_bclk = 1'b1;
        repeat (HALF) @(negedge clk_ref_external);
    endtask

    task automatic send_frame(input logic [63:0] lv, input int ln, input logic [63:0] rv, input int rn,
                              input bit keep);
        if (!lead_sent) send_bit(1'b0, pend);
        lead_sent = 1'b0;
        for (int i = ln - 1; i >= 1; i--) send_bit(1'b0, lv[i]);
        send_bit(1'b1, lv[0]);
        for (int i = rn - 1; i >= 1; i--) send_bit(1'b1, rv[i]);
        pend = rv[0];
        if (keep) begin
            exp_l.push_back(exp_word(lv, ln));
            exp_r.push_back(exp_word(rv, rn));
        end
    endtask

    // Sends the falling-LRCLK bit that carries the pending right LSB; optionally times out_valid.
    task automatic finish(input bit lat);
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_data = pend;
        repeat (HALF) @(negedge clk_ref_external);
        i2s_bclk = 1'b1;
        repeat (HALF - 1) @(negedge clk_ref_external);
        if (lat) chk("latency_early", out_valid, 1'b0);
        @(negedge clk_ref_external);
        if (lat) chk("latency_rise", out_valid, 1'b1);
        lead_sent = 1'b1;
        @(negedge clk_ref_external);
    endtask

    task automatic check_pairs(input string tag);
        chk({tag, "_count"}, 64'(acc_l.size() - rd_idx), 64'(exp_l.size()));
        for (int i = 0; i < exp_l.size(); i++) begin
            if (rd_idx + i < acc_l.size()) begin
                chk({tag, "_left"}, acc_l[rd_idx + i], exp_l[i]);
                chk({tag, "_right"}, acc_r[rd_idx + i], exp_r[i]);
            end
        end
        rd_idx = acc_l.size();
        exp_l.delete();
        exp_r.delete();
    endtask

    task automatic snap();
        b_vld = vld_rises; b_ovr = ovr_cnt; b_ferr = ferr_cnt;
    endtask

    initial begin
        logic [63:0] a, b, c, d;
        int          ln, rn;
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_data = 1'b0;
        repeat (3) @(negedge clk_ref_external);
        chk("rst_out_left", out_left, 0);
        chk("rst_out_right", out_right, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lr_period", lr_period, 0);
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk_ref_external);

        // Nominal 32-bit slots; first frame uses the reference words.
        snap();
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk("prelock_locked", locked, 0);
        send_frame({24'hA5A5A5, 8'($urandom)}, 32, {24'h5A5A5A, 8'($urandom)}, 32, 1);
        for (int k = 0; k < 3; k++) send_frame(rand_val(32), 32, rand_val(32), 32, 1);
        finish(1);
        check_pairs("s32");
        chk("s32_valid_pulses", 64'(vld_rises - b_vld), 4);
        chk("s32_locked", locked, 1);
        chk("s32_overrun", 64'(ovr_cnt - b_ovr), 0);
        chk("s32_frame_err", 64'(ferr_cnt - b_ferr), 0);
`ifdef KOSEI_I2S_RX_RATE_DET_EN
        chk("lr_period_64bclk", lr_period, 512);
`else
        chk("lr_period_off", lr_period, 0);
`endif

        // 16-bit slots, then random slot widths from MIN_BITS up past DATA_W.
        send_frame(64'h1234, 16, 64'hBEEF, 16, 1);
        for (int k = 0; k < 2; k++) send_frame(rand_val(16), 16, rand_val(16), 16, 1);
        for (int k = 0; k < 4; k++) begin
            ln = (k == 0) ? 8 : $urandom_range(8, 40);
            rn = $urandom_range(8, 40);
            send_frame(rand_val(ln), ln, rand_val(rn), rn, 1);
        end
        finish(0);
        check_pairs("mixed");

        // Two frames with the consumer stalled.
        snap();
        out_ready = 1'b0;
        a = rand_val(32); b = rand_val(32); c = rand_val(32); d = rand_val(32);
        send_frame(a, 32, b, 32, 0);
        send_frame(c, 32, d, 32, 0);
        finish(0);
        chk("ovr_pulses", 64'(ovr_cnt - b_ovr), 1);
        chk("ovr_valid_held", out_valid, 1);
        chk("ovr_left", out_left, exp_word(c, 32));
        chk("ovr_right", out_right, exp_word(d, 32));
        out_ready = 1'b1;
        @(negedge clk_ref_external);
        chk("ovr_valid_cleared", out_valid, 0);
        @(negedge clk_ref_external);
        rd_idx = acc_l.size();

        // Short right slot, then resync on the following frames.
        snap();
        send_frame(rand_val(32), 32, rand_val(4), 4, 0);
        finish(0);
        chk("short_frame_err", 64'(ferr_cnt - b_ferr), 1);
        chk("short_locked", locked, 0);
        chk("short_no_valid", 64'(vld_rises - b_vld), 0);
        send_frame(rand_val(32), 32, rand_val(32), 32, 0);
        send_frame(rand_val(32), 32, rand_val(32), 32, 1);
        finish(0);
        check_pairs("resync");
        chk("resync_locked", locked, 1);
        chk("resync_frame_err", 64'(ferr_cnt - b_ferr), 1);

        // BCLK stall beyond the timeout.
        snap();
        repeat (1100) @(negedge clk_ref_external);
        chk("timeout_locked", locked, 0);
        chk("timeout_no_frame_err", 64'(ferr_cnt - b_ferr), 0);
        lead_sent = 1'b0;
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        send_frame(rand_val(32), 32, rand_val(32), 32, 1);
        finish(0);
        check_pairs("relock");
        chk("relock_locked", locked, 1);

        // Reset in the middle of a left slot.
        for (int k = 0; k < 10; k++) send_bit(1'b0, 1'($urandom));
        rst_n = 1'b0;
        repeat (2) @(negedge clk_ref_external);
        chk("midrst_left", out_left, 0);
        chk("midrst_right", out_right, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_lr_period", lr_period, 0);
        rst_n = 1'b1;
        @(negedge clk_ref_external);
        for (int k = 0; k < 20; k++) send_bit(1'b0, 1'($urandom));
        for (int k = 0; k < 32; k++) send_bit(1'b1, 1'($urandom));
        lead_sent = 1'b0;
        pend = 1'($urandom);
        send_frame(rand_val(32), 32, rand_val(32), 32, 1);
        finish(0);
        check_pairs("post_rst");
        chk("post_rst_locked", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
